// File: rtl/game_raster_scaler.sv
// VGA timing generator that maps the physical beam onto a centred,
// integer-upscaled game window and emits game-pixel coordinates and strobes.
module game_raster_scaler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int GAME_W   = 224,
  parameter int GAME_H   = 288,
  parameter int SCALE    = 1,
  parameter int SYNC_NEG = 1
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      vga_de,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic                      display_enabled
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_OFF   = (H_ACTIVE - GAME_W * SCALE) / 2;
  localparam int V_OFF   = (V_ACTIVE - GAME_H * SCALE) / 2;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW      = $clog2(GAME_W);
  localparam int YW      = $clog2(GAME_H);

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_LO   = HCW'(H_OFF);
  localparam logic [HCW-1:0] H_HI   = HCW'(H_OFF + GAME_W * SCALE);
  localparam logic [HCW-1:0] HS_LO  = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_HI  = HCW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_LO   = VCW'(V_OFF);
  localparam logic [VCW-1:0] V_HI   = VCW'(V_OFF + GAME_H * SCALE);
  localparam logic [VCW-1:0] VS_LO  = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_HI  = VCW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
  localparam logic [XW-1:0] X_LAST = XW'(GAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GAME_H - 1);
  localparam logic          SYNC_ON = (SYNC_NEG != 0) ? 1'b0 : 1'b1;

  if (SCALE < 1 || SCALE > 4 ||
      GAME_W * SCALE > H_ACTIVE ||
      GAME_H * SCALE > V_ACTIVE) begin : g_bad_cfg
    $error("game_raster_scaler: window does not fit or SCALE out of range");
  end

  logic [HCW-1:0] h_q, h_d;
  logic [VCW-1:0] v_q, v_d;
  logic [SW-1:0]  hsub_q, hsub_d;
  logic [SW-1:0]  vsub_q, vsub_d;
  logic [XW-1:0]  gx_q, gx_d;
  logic [YW-1:0]  gy_q, gy_d;

  logic h_end, v_end;
  logic hwin, vwin, win;

  always_comb begin
    h_end  = (h_q == H_LAST);
    v_end  = (v_q == V_LAST);
    hwin   = (h_q >= H_LO) && (h_q < H_HI);
    vwin   = (v_q >= V_LO) && (v_q < V_HI);
    win    = hwin && vwin;
    h_d    = h_end ? '0 : h_q + 1'b1;
    v_d    = v_q;
    hsub_d = hsub_q;
    gx_d   = gx_q;
    vsub_d = vsub_q;
    gy_d   = gy_q;
    if (h_end) begin
      v_d = v_end ? '0 : v_q + 1'b1;
    end
    // Column state is primed one clock early so it is valid at h=H_OFF.
    if (h_d == H_LO) begin
      hsub_d = '0;
      gx_d   = '0;
    end else if (hwin) begin
      if (hsub_q == S_LAST) begin
        hsub_d = '0;
        if (gx_q != X_LAST) gx_d = gx_q + 1'b1;
      end else begin
        hsub_d = hsub_q + 1'b1;
      end
    end
    if (h_end) begin
      if (v_d == V_LO) begin
        vsub_d = '0;
        gy_d   = '0;
      end else if (vwin) begin
        if (vsub_q == S_LAST) begin
          vsub_d = '0;
          if (gy_q != Y_LAST) gy_d = gy_q + 1'b1;
        end else begin
          vsub_d = vsub_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vga_pix_clk or negedge rst) begin
    if (!rst) begin
      h_q    <= '0;
      v_q    <= '0;
      hsub_q <= '0;
      vsub_q <= '0;
      gx_q   <= '0;
      gy_q   <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
    end
  end

  always_ff @(posedge vga_pix_clk or negedge rst) begin
    if (!rst) begin
      hsync           <= ~SYNC_ON;
      vsync           <= ~SYNC_ON;
      vga_de          <= 1'b0;
      sx              <= '0;
      sy              <= '0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
      display_enabled <= 1'b0;
    end else begin
      hsync <= (h_q >= HS_LO && h_q < HS_HI) ? SYNC_ON : ~SYNC_ON;
      vsync <= (v_q >= VS_LO && v_q < VS_HI) ? SYNC_ON : ~SYNC_ON;
      vga_de          <= (h_q < H_ACT) && (v_q < V_ACT);
      sx              <= win ? gx_q : '0;
      sy              <= win ? gy_q : '0;
      game_pix_stb    <= win && hsub_q == '0 && vsub_q == '0;
      frame_stb       <= win && gx_q == '0 && gy_q == '0 &&
                         hsub_q == '0 && vsub_q == '0;
      display_enabled <= win;
    end
  end

endmodule

// File: tb/tb_game_raster_scaler.sv
// Directed bench: default 640x480 instance plus a tiny SCALE=2 instance
// small enough to run many whole frames.
module tb_game_raster_scaler;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       hs_b, vs_b, de_b, pix_b, frm_b, en_b;
  logic [7:0] sx_b;
  logic [8:0] sy_b;

  logic       hs_s, vs_s, de_s, pix_s, frm_s, en_s;
  logic [2:0] sx_s;
  logic [2:0] sy_s;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  game_raster_scaler u_big (
    .vga_pix_clk     (clk),
    .rst             (rst),
    .hsync           (hs_b),
    .vsync           (vs_b),
    .vga_de          (de_b),
    .sx              (sx_b),
    .sy              (sy_b),
    .game_pix_stb    (pix_b),
    .frame_stb       (frm_b),
    .display_enabled (en_b)
  );

  // 28x21 total, 20x16 active, 6x5 game window at SCALE 2: offsets 4,3
  game_raster_scaler #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .GAME_W(6), .GAME_H(5), .SCALE(2), .SYNC_NEG(0)
  ) u_small (
    .vga_pix_clk     (clk),
    .rst             (rst),
    .hsync           (hs_s),
    .vsync           (vs_s),
    .vga_de          (de_s),
    .sx              (sx_s),
    .sy              (sy_s),
    .game_pix_stb    (pix_s),
    .frame_stb       (frm_s),
    .display_enabled (en_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (hs_b !== 1'b1) $display("FAIL reset_hsync: got %b want 1", hs_b);
    else passed++;
    checks++;
    if (vs_b !== 1'b1) $display("FAIL reset_vsync: got %b want 1", vs_b);
    else passed++;
    checks++;
    if ({de_b, pix_b, frm_b, en_b} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000",
               {de_b, pix_b, frm_b, en_b});
    else passed++;
    checks++;
    if (sx_b !== 8'd0 || sy_b !== 9'd0)
      $display("FAIL reset_xy: got %0d,%0d want 0,0", sx_b, sy_b);
    else passed++;
    checks++;
    if ({hs_s, vs_s, de_s, pix_s, frm_s, en_s} !== 6'b000000)
      $display("FAIL reset_small: got %b want 000000",
               {hs_s, vs_s, de_s, pix_s, frm_s, en_s});
    else passed++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if ({de_b, en_b, hs_b} !== 3'b101)
      $display("FAIL first_clock: got de/en/hs %b want 101",
               {de_b, en_b, hs_b});
    else passed++;
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (de_b !== 1'b0)
      $display("FAIL async_de: got %b want 0", de_b);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (700) tick();
    checks++;
    if (hs_b !== 1'b0)
      $display("FAIL hsync_at_699: got %b want 0", hs_b);
    else passed++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (hs_b !== 1'b1)
      $display("FAIL async_hsync: got %b want 1", hs_b);
    else passed++;
  endtask

  task automatic test_free_run();
    int n;
    int p, h, v, h2, v2, s_full;
    logic e_hs, e_vs, e_de, win, w2;
    int e_hs_n, e_vs_n, e_de_n, e_en_n, e_xy_n, e_pix_n;
    int s_err, s_err_at;
    int frm_cnt, frm_first, en_l96, hs_l10, de_l5;
    int s_pix_tot, s_frm_tot;
    logic [7:0] frm_sx;
    logic [8:0] frm_sy;
    logic       frm_en;
    n = 77300;
    s_full = n / 588;
    {e_hs_n, e_vs_n, e_de_n, e_en_n, e_xy_n, e_pix_n} = '0;
    s_err = 0; s_err_at = 0;
    frm_cnt = 0; frm_first = 0;
    en_l96 = 0; hs_l10 = 0; de_l5 = 0;
    s_pix_tot = 0; s_frm_tot = 0;
    frm_sx = '1; frm_sy = '1; frm_en = 1'b0;
    rst = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      p = i - 1;
      h = p % 800;
      v = p / 800;
      e_hs = !(h >= 656 && h < 752);
      e_vs = !(v >= 490 && v < 492);
      e_de = (h < 640) && (v < 480);
      win  = (h >= 208) && (h < 432) && (v >= 96) && (v < 384);
      if (hs_b !== e_hs) e_hs_n++;
      if (vs_b !== e_vs) e_vs_n++;
      if (de_b !== e_de) e_de_n++;
      if (en_b !== win) e_en_n++;
      if (pix_b !== win) e_pix_n++;
      if (win && (sx_b !== 8'(h - 208) || sy_b !== 9'(v - 96))) e_xy_n++;
      if (!win && (sx_b !== 8'd0 || sy_b !== 9'd0)) e_xy_n++;
      if (frm_b) begin
        frm_cnt++;
        if (frm_cnt == 1) begin
          frm_first = i;
          frm_sx = sx_b;
          frm_sy = sy_b;
          frm_en = en_b;
        end
      end
      if (v == 96 && en_b) en_l96++;
      if (v == 10 && !hs_b) hs_l10++;
      if (v == 5 && de_b) de_l5++;
      h2 = p % 28;
      v2 = (p / 28) % 21;
      w2 = (h2 >= 4) && (h2 < 16) && (v2 >= 3) && (v2 < 13);
      if (hs_s !== (h2 >= 22 && h2 < 25) ||
          vs_s !== (v2 >= 17 && v2 < 19) ||
          de_s !== (h2 < 20 && v2 < 16) ||
          en_s !== w2 ||
          sx_s !== (w2 ? 3'((h2 - 4) / 2) : 3'd0) ||
          sy_s !== (w2 ? 3'((v2 - 3) / 2) : 3'd0) ||
          pix_s !== (w2 && (h2 % 2 == 0) && (v2 % 2 == 1)) ||
          frm_s !== (h2 == 4 && v2 == 3)) begin
        if (s_err == 0) s_err_at = i;
        s_err++;
      end
      if (p < s_full * 588) begin
        if (pix_s) s_pix_tot++;
        if (frm_s) s_frm_tot++;
      end
    end
    checks++;
    if (e_hs_n != 0) $display("FAIL hsync_big: got %0d bad clocks want 0", e_hs_n);
    else passed++;
    checks++;
    if (e_vs_n != 0) $display("FAIL vsync_big: got %0d bad clocks want 0", e_vs_n);
    else passed++;
    checks++;
    if (e_de_n != 0) $display("FAIL vga_de_big: got %0d bad clocks want 0", e_de_n);
    else passed++;
    checks++;
    if (e_en_n != 0) $display("FAIL window_big: got %0d bad clocks want 0", e_en_n);
    else passed++;
    checks++;
    if (e_pix_n != 0) $display("FAIL pix_stb_big: got %0d bad clocks want 0", e_pix_n);
    else passed++;
    checks++;
    if (e_xy_n != 0) $display("FAIL sxsy_big: got %0d bad clocks want 0", e_xy_n);
    else passed++;
    checks++;
    if (frm_cnt != 1 || frm_first != 77009)
      $display("FAIL frame_stb_big: got %0d pulses first at %0d want 1 at 77009",
               frm_cnt, frm_first);
    else passed++;
    checks++;
    if (frm_sx !== 8'd0 || frm_sy !== 9'd0 || frm_en !== 1'b1)
      $display("FAIL frame_pos_big: got sx %0d sy %0d en %b want 0 0 1",
               frm_sx, frm_sy, frm_en);
    else passed++;
    checks++;
    if (en_l96 != 224) $display("FAIL line96_width: got %0d want 224", en_l96);
    else passed++;
    checks++;
    if (hs_l10 != 96) $display("FAIL hsync_width: got %0d want 96", hs_l10);
    else passed++;
    checks++;
    if (de_l5 != 640) $display("FAIL de_width: got %0d want 640", de_l5);
    else passed++;
    checks++;
    if (s_err != 0)
      $display("FAIL small_decode: got %0d bad clocks first at %0d want 0",
               s_err, s_err_at);
    else passed++;
    checks++;
    if (s_pix_tot != 30 * s_full)
      $display("FAIL small_pix_count: got %0d want %0d", s_pix_tot, 30 * s_full);
    else passed++;
    checks++;
    if (s_frm_tot != s_full)
      $display("FAIL small_frame_count: got %0d want %0d", s_frm_tot, s_full);
    else passed++;
  endtask

  task automatic test_mid_frame_reset();
    int big_frm, hs_first, s_first, s_cnt;
    big_frm = 0; hs_first = 0; s_first = 0; s_cnt = 0;
    #2 rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (i == 1) begin
        checks++;
        if (de_b !== 1'b1 || en_b !== 1'b0 || sx_b !== 8'd0)
          $display("FAIL restart_pos: got de %b en %b sx %0d want 1 0 0",
                   de_b, en_b, sx_b);
        else passed++;
      end
      if (frm_b) big_frm++;
      if (!hs_b && hs_first == 0) hs_first = i;
      if (frm_s) begin
        if (s_cnt == 0) s_first = i;
        s_cnt++;
      end
    end
    checks++;
    if (big_frm != 0) $display("FAIL restart_frame_big: got %0d want 0", big_frm);
    else passed++;
    checks++;
    if (hs_first != 657) $display("FAIL restart_hsync: got %0d want 657", hs_first);
    else passed++;
    checks++;
    if (s_first != 89 || s_cnt != 4)
      $display("FAIL restart_frame_small: got first %0d count %0d want 89 4",
               s_first, s_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_free_run();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
